// File: rtl/ritc_phase_scan_ctrl.sv
// ritc_phase_scan_ctrl
//   Sequences a RITC clock-phase scan. It steps CLK_PS through the MMCM dynamic
//   phase-shift port and issues a scan request at each step. It samples the
//   synchronized clock and VCDL bits and records the first 0->1 edge of each.
//   After the sweep it walks the MMCM back to its starting phase.
//   Everything runs in the user_clk_i domain.
//
// Optional feature macro: RITC_PS_MAJORITY_EN
//   When defined, each step runs three scan/settle/sample passes. The value
//   used for edge detection is the bitwise 2-of-3 majority of the passes.
//
// Ports
//   user_clk_i              system clock, also the MMCM PSCLK
//   user_rst_n_i            asynchronous active-low reset
//   start_i                 start pulse, honoured only when idle
//   abort_i                 abort pulse; ends the sweep early and restores phase
//   ps_en_o, ps_incdec_o    MMCM PSEN pulse and PSINCDEC (1 = increment)
//   ps_done_i               MMCM PSDONE
//   scan_o                  one-cycle scan request to the phase scanner
//   clk_q_i, vcdl_q_i       synchronized samples from the phase scanner
//   busy_o, done_o          sweep in progress / end-of-sweep pulse
//   timeout_o               sticky flag; PSDONE did not arrive in time
//   edge_found_o            per-channel edge-found flags
//   edge_pos0/1/2_o         step index of the first 0->1 edge per channel
//   vcdl_pos_o              step index of the first VCDL 0->1 edge (0 = none)
module ritc_phase_scan_ctrl #(
    parameter int unsigned NSTEPS     = 1024,
    parameter int unsigned STEP_BITS  = 11,
    parameter int unsigned SETTLE     = 8,
    parameter int unsigned PS_TIMEOUT = 255
) (
    input  logic                 user_clk_i,
    input  logic                 user_rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 ps_en_o,
    output logic                 ps_incdec_o,
    input  logic                 ps_done_i,
    output logic                 scan_o,
    input  logic [2:0]           clk_q_i,
    input  logic                 vcdl_q_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [2:0]           edge_found_o,
    output logic [STEP_BITS-1:0] edge_pos0_o,
    output logic [STEP_BITS-1:0] edge_pos1_o,
    output logic [STEP_BITS-1:0] edge_pos2_o,
    output logic [STEP_BITS-1:0] vcdl_pos_o
);

    localparam int unsigned SetW = $clog2(SETTLE + 1);
    localparam int unsigned ToW  = $clog2(PS_TIMEOUT + 1);

    localparam logic [STEP_BITS-1:0] LastStep   = STEP_BITS'(NSTEPS - 1);
    localparam logic [SetW-1:0]      SettleLoad = SetW'(SETTLE);
    localparam logic [ToW-1:0]       ToLoad     = ToW'(PS_TIMEOUT);

    typedef enum logic [3:0] {
        StIdle, StScan, StSettle, StSample, StShift,
        StWaitPs, StReturn, StRwait, StFinish
    } state_e;

    state_e               state_q, state_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [STEP_BITS-1:0] shifted_q, shifted_d;
    logic [SetW-1:0]      settle_q, settle_d;
    logic [ToW-1:0]       tmo_q, tmo_d;
    logic                 abort_pend_q, abort_pend_d;
    logic [3:0]           prev_q, prev_d;      // {vcdl, clk[2:0]} from previous step
    logic [2:0]           found_q, found_d;
    logic [STEP_BITS-1:0] pos_q [3];
    logic [STEP_BITS-1:0] pos_d [3];
    logic [STEP_BITS-1:0] vpos_q, vpos_d;
    logic                 timeout_q, timeout_d;
    logic [3:0]           cur_raw, cur;

    assign cur_raw = {vcdl_q_i, clk_q_i};

`ifdef RITC_PS_MAJORITY_EN
    logic [1:0] pass_q, pass_d;
    logic [3:0] samp0_q, samp0_d;
    logic [3:0] samp1_q, samp1_d;

    // The third pass is taken live in SAMPLE; the first two are held.
    assign cur = (samp0_q & samp1_q) | (samp0_q & cur_raw) | (samp1_q & cur_raw);
`else
    assign cur = cur_raw;
`endif

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        shifted_d    = shifted_q;
        settle_d     = settle_q;
        tmo_d        = tmo_q;
        abort_pend_d = abort_pend_q;
        prev_d       = prev_q;
        found_d      = found_q;
        pos_d        = pos_q;
        vpos_d       = vpos_q;
        timeout_d    = timeout_q;
`ifdef RITC_PS_MAJORITY_EN
        pass_d       = pass_q;
        samp0_d      = samp0_q;
        samp1_d      = samp1_q;
`endif

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    found_d      = '0;
                    pos_d        = '{default: '0};
                    vpos_d       = '0;
                    timeout_d    = 1'b0;
                    step_d       = '0;
                    shifted_d    = '0;
                    prev_d       = '0;
                    abort_pend_d = 1'b0;
`ifdef RITC_PS_MAJORITY_EN
                    pass_d       = '0;
`endif
                    state_d      = StScan;
                end
            end
            StScan: begin
                settle_d = SettleLoad;
                state_d  = abort_i ? StReturn : StSettle;
            end
            StSettle: begin
                if (abort_i) begin
                    state_d = StReturn;
                end else if (settle_q <= SetW'(1)) begin
`ifdef RITC_PS_MAJORITY_EN
                    if (pass_q == 2'd0) begin
                        samp0_d = cur_raw;
                        pass_d  = 2'd1;
                        state_d = StScan;
                    end else if (pass_q == 2'd1) begin
                        samp1_d = cur_raw;
                        pass_d  = 2'd2;
                        state_d = StScan;
                    end else begin
                        state_d = StSample;
                    end
`else
                    state_d = StSample;
`endif
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StSample: begin
                // Step 0 only seeds prev; an edge needs a real predecessor.
                for (int c = 0; c < 3; c++) begin
                    if (step_q != '0 && !prev_q[c] && cur[c] && !found_q[c]) begin
                        found_d[c] = 1'b1;
                        pos_d[c]   = step_q;
                    end
                end
                if (step_q != '0 && !prev_q[3] && cur[3] && vpos_q == '0) begin
                    vpos_d = step_q;
                end
                prev_d = cur;
`ifdef RITC_PS_MAJORITY_EN
                pass_d = '0;
`endif
                if (abort_i || step_q == LastStep) begin
                    state_d = StReturn;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                // An abort here suppresses the PSEN pulse (see ps_en_o).
                if (abort_i) begin
                    state_d = StReturn;
                end else begin
                    tmo_d        = ToLoad;
                    abort_pend_d = 1'b0;
                    state_d      = StWaitPs;
                end
            end
            StWaitPs: begin
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                if (ps_done_i) begin
                    step_d    = step_q + STEP_BITS'(1);
                    shifted_d = shifted_q + STEP_BITS'(1);
                    state_d   = (abort_pend_q || abort_i) ? StReturn : StScan;
                end else if (tmo_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = StFinish;
                end else begin
                    tmo_d = tmo_q - ToW'(1);
                end
            end
            StReturn: begin
                if (shifted_q == '0) begin
                    state_d = StFinish;
                end else begin
                    tmo_d   = ToLoad;
                    state_d = StRwait;
                end
            end
            StRwait: begin
                if (ps_done_i) begin
                    shifted_d = shifted_q - STEP_BITS'(1);
                    state_d   = StReturn;
                end else if (tmo_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = StFinish;
                end else begin
                    tmo_d = tmo_q - ToW'(1);
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_q      <= StIdle;
            step_q       <= '0;
            shifted_q    <= '0;
            settle_q     <= '0;
            tmo_q        <= '0;
            abort_pend_q <= 1'b0;
            prev_q       <= '0;
            found_q      <= '0;
            pos_q        <= '{default: '0};
            vpos_q       <= '0;
            timeout_q    <= 1'b0;
`ifdef RITC_PS_MAJORITY_EN
            pass_q       <= '0;
            samp0_q      <= '0;
            samp1_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            shifted_q    <= shifted_d;
            settle_q     <= settle_d;
            tmo_q        <= tmo_d;
            abort_pend_q <= abort_pend_d;
            prev_q       <= prev_d;
            found_q      <= found_d;
            pos_q        <= pos_d;
            vpos_q       <= vpos_d;
            timeout_q    <= timeout_d;
`ifdef RITC_PS_MAJORITY_EN
            pass_q       <= pass_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
`endif
        end
    end

    // SHIFT and RETURN each last one cycle, so PSEN is naturally a single pulse.
    assign ps_en_o      = (state_q == StShift && !abort_i) ||
                          (state_q == StReturn && shifted_q != '0);
    assign ps_incdec_o  = (state_q != StReturn);
    assign scan_o       = (state_q == StScan);
    assign busy_o       = (state_q != StIdle) && (state_q != StFinish);
    assign done_o       = (state_q == StFinish);
    assign timeout_o    = timeout_q;
    assign edge_found_o = found_q;
    assign edge_pos0_o  = pos_q[0];
    assign edge_pos1_o  = pos_q[1];
    assign edge_pos2_o  = pos_q[2];
    assign vcdl_pos_o   = vpos_q;

endmodule

// File: tb/tb_ritc_phase_scan_ctrl.sv
// Self-checking bench for ritc_phase_scan_ctrl (NSTEPS=16, SETTLE=4).
// An MMCM model returns ps_done 3 cycles after each ps_en. The scanner inputs
// are a function of the step the model has been shifted to. The expected
// results of each sweep are queued at start and compared at done_o.
module tb_ritc_phase_scan_ctrl;

    localparam int unsigned NSTEPS = 16;
    localparam int unsigned SB     = 11;
`ifdef RITC_PS_MAJORITY_EN
    localparam int PASSES = 3;
    localparam bit GLITCH = 1'b1;
`else
    localparam int PASSES = 1;
    localparam bit GLITCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ps_en, ps_incdec, ps_done, scan;
    logic [2:0]    clk_q;
    logic          vcdl_q;
    logic          busy, done, timeout;
    logic [2:0]    found;
    logic [SB-1:0] pos0, pos1, pos2, vpos;

    ritc_phase_scan_ctrl #(
        .NSTEPS(NSTEPS), .STEP_BITS(SB), .SETTLE(4), .PS_TIMEOUT(255)
    ) dut (
        .user_clk_i(clk), .user_rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .ps_en_o(ps_en), .ps_incdec_o(ps_incdec), .ps_done_i(ps_done), .scan_o(scan),
        .clk_q_i(clk_q), .vcdl_q_i(vcdl_q), .busy_o(busy), .done_o(done),
        .timeout_o(timeout), .edge_found_o(found), .edge_pos0_o(pos0),
        .edge_pos1_o(pos1), .edge_pos2_o(pos2), .vcdl_pos_o(vpos)
    );

    always #5 clk = ~clk;

    // Model state and event counters
    logic        clr = 1'b0;
    logic        drop = 1'b0;
    bit          glitch_en = 1'b0;
    int          th0 = 5;
    int          thv = 9;
    logic [15:0] tb_step = '0;
    int          pass_cnt = 0;
    int          incs = 0, decs = 0, scans = 0, dones = 0;
    int          cyc = 0, inc3_cyc = 0;
    int          dly = 0;

    assign clk_q  = {tb_step[0], 1'b1,
                     (int'(tb_step) >= th0) | (glitch_en && tb_step == 16'd3 && pass_cnt == 2)};
    assign vcdl_q = (int'(tb_step) >= thv);

    initial ps_done = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            dly     <= 0;
            ps_done <= 1'b0;
        end else begin
            ps_done <= (dly == 1);
            if (dly != 0) dly <= dly - 1;
            if (ps_en && !(drop && ps_incdec && incs == 2)) dly <= 3;
        end
        if (clr) begin
            incs <= 0; decs <= 0; scans <= 0; dones <= 0; tb_step <= '0; pass_cnt <= 0;
        end else begin
            if (ps_en) begin
                if (ps_incdec) begin
                    incs     <= incs + 1;
                    tb_step  <= tb_step + 16'd1;
                    pass_cnt <= 0;
                    if (incs == 2) inc3_cyc <= cyc;
                end else begin
                    decs <= decs + 1;
                end
            end
            if (scan) begin
                scans    <= scans + 1;
                pass_cnt <= pass_cnt + 1;
            end
            if (done) dones <= dones + 1;
        end
    end

    typedef struct {
        string      name;
        logic [2:0] found;
        int         pos0, pos1, pos2, vpos;
        bit         tmo;
        int         incs, decs, scans;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic kick(input exp_t e);
        sb.push_back(e);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) begin clr = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
    endtask

    task automatic finish_sweep(input int budget);
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({e.name, "/done_within_budget"}, 0, 1);
            return;
        end
        done_cyc = cyc;
        chk({e.name, "/busy_at_done"}, busy, 0);
        chk({e.name, "/found"}, found, e.found);
        chk({e.name, "/pos0"}, pos0, e.pos0);
        chk({e.name, "/pos1"}, pos1, e.pos1);
        chk({e.name, "/pos2"}, pos2, e.pos2);
        chk({e.name, "/vcdl_pos"}, vpos, e.vpos);
        chk({e.name, "/timeout"}, timeout, e.tmo);
        repeat (3) @(negedge clk);
        chk({e.name, "/incs"}, incs, e.incs);
        chk({e.name, "/decs"}, decs, e.decs);
        chk({e.name, "/scans"}, scans, e.scans);
        chk({e.name, "/dones"}, dones, 1);
        chk({e.name, "/busy_after"}, busy, 0);
        chk({e.name, "/pos0_held"}, pos0, e.pos0);
    endtask

    task automatic wait_until_incs(input int n, input bit need_scan, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (incs == n && (!need_scan || scan === 1'b1)) ok = 1'b1;
        end
        if (!ok) chk({tag, "/wait_step"}, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/ps_en", ps_en, 0);
        chk("rst/ps_incdec", ps_incdec, 1);
        chk("rst/scan", scan, 0);
        chk("rst/timeout", timeout, 0);
        chk("rst/found", found, 0);
        chk("rst/vcdl_pos", vpos, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full sweep: ch0 edge at 5, ch1 stuck high, ch2 toggling, VCDL edge at 9.
        // A start pulse mid-sweep must be ignored.
        th0 = 5; thv = 9;
        e = '{name: "sweep", found: 3'b101, pos0: 5, pos1: 0, pos2: 1, vpos: 9, tmo: 1'b0,
              incs: 15, decs: 15, scans: 16 * PASSES};
        kick(e);
        repeat (30) @(negedge clk);
        chk("sweep/busy_mid", busy, 1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        finish_sweep(4000);

        // Abort during SETTLE of step 6
        e = '{name: "abort", found: 3'b101, pos0: 5, pos1: 0, pos2: 1, vpos: 0, tmo: 1'b0,
              incs: 6, decs: 6, scans: 6 * PASSES + 1};
        kick(e);
        wait_until_incs(6, 1'b1, "abort");
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        finish_sweep(4000);

        // PSDONE lost on the third increment
        drop = 1'b1;
        e = '{name: "tmo", found: 3'b100, pos0: 0, pos1: 0, pos2: 1, vpos: 0, tmo: 1'b1,
              incs: 3, decs: 0, scans: 3 * PASSES};
        kick(e);
        finish_sweep(4000);
        chk("tmo/latency_near_256", ((done_cyc - inc3_cyc) >= 250 &&
                                     (done_cyc - inc3_cyc) <= 262), 1);
        drop = 1'b0;

        // Asynchronous reset while waiting for PSDONE, then a clean sweep
        e = '{name: "rst_mid", found: 3'b101, pos0: 5, pos1: 0, pos2: 1, vpos: 9, tmo: 1'b0,
              incs: 15, decs: 15, scans: 16 * PASSES};
        @(negedge clk) clr = 1'b1;
        @(negedge clk) begin clr = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        wait_until_incs(2, 1'b0, "rst_mid");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/found", found, 0);
        chk("rst_mid/pos2", pos2, 0);
        chk("rst_mid/ps_en", ps_en, 0);
        chk("rst_mid/scan", scan, 0);
        chk("rst_mid/ps_incdec", ps_incdec, 1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        kick(e);
        finish_sweep(4000);

        // Late edge at step 8; with majority voting a one-pass glitch at step 3 is rejected
        th0 = 8; glitch_en = GLITCH;
        e = '{name: "late", found: 3'b101, pos0: 8, pos1: 0, pos2: 1, vpos: 9, tmo: 1'b0,
              incs: 15, decs: 15, scans: 16 * PASSES};
        kick(e);
        finish_sweep(4000);
        glitch_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
